mult_hilo_ctrl: RTL and testbench
=================================

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 Parameter: MAX_CYCLES, default 40, watchdog limit in cycles from launch to completion.
REQ-002 Ports: clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-003 Ports: op_valid  in  1  execute-stage op present; op_code  in  3  operation; op_rs, op_rt  in  32  operands.
REQ-004 Ports: flush  in  1  squash presented op; kill  in  1  cancel in-flight multiply.
REQ-005 Ports: stall  out  1  hold pipeline; rd_data  out  32  MFHI/MFLO data; rd_valid  out  1  rd_data valid.
REQ-006 Ports: hi, lo  out  32  architectural HI/LO; busy  out  1  state != IDLE; timeout_err  out  1  sticky watchdog flag.
REQ-007 Ports: mult_start  out  1; mult_a, mult_b  out  32; mult_is_signed  out  1; mult_s  in  64; mult_active  in  1. These connect to the multi-cycle multiplier.

Function
REQ-008 op_code values SHALL be: 0 NOP, 1 MULT, 2 MULTU, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO; 7 is treated as NOP.
REQ-009 FSM states SHALL be IDLE, LAUNCH, WAIT_ACT, BUSY.
REQ-010 stall SHALL be combinational: op_valid and op_code in 1..6 and state != IDLE.
REQ-011 An op is accepted when op_valid, not stall, not flush, and op_code is in 1..6.
REQ-012 On accepted MULT/MULTU: at the next edge, register op_rs->mult_a, op_rt->mult_b, is_signed=(op_code==1); IDLE->LAUNCH.
REQ-013 In LAUNCH: mult_start=1 for exactly one cycle, watchdog cleared; ->WAIT_ACT.
REQ-014 In WAIT_ACT: mult_active=1 ->BUSY; otherwise stay.
REQ-015 In BUSY: mult_active=0 -> {hi,lo}<=mult_s unless abort is set; ->IDLE.
REQ-016 Stall SHALL deassert in the first IDLE cycle, so a held MFHI/MFLO returns the new product.
REQ-017 MFHI/MFLO accepted: same-cycle combinational rd_valid=1, rd_data=hi/lo; otherwise rd_valid=0 and rd_data=0.
REQ-018 MTHI/MTLO accepted: hi/lo <= op_rs at the next edge.
REQ-019 kill while state != IDLE SHALL set abort. The FSM still waits for mult_active to fall, then leaves HI/LO unchanged. abort clears on entering IDLE.
REQ-020 kill in IDLE SHALL be ignored. kill in the same cycle as completion SHALL discard the result.
REQ-021 flush with op_valid SHALL not accept the op and SHALL leave state unchanged.
REQ-022 Watchdog SHALL count cycles in WAIT_ACT/BUSY. On reaching MAX_CYCLES: timeout_err<=1 (sticky until reset), ->IDLE, HI/LO unchanged.
REQ-023 mult_a/mult_b/mult_is_signed SHALL hold stable from LAUNCH until the return to IDLE.

Reset
REQ-024 reset SHALL, at the next edge: state=IDLE; hi, lo, mult_a, mult_b = 0; mult_start, mult_is_signed, abort, timeout_err, watchdog = 0.
REQ-025 Reset mid-operation SHALL discard the in-flight product.
REQ-026 No output SHALL be X after the first reset edge.

Structure
REQ-027 op_code encodings and FSM state encodings SHALL live in a shared package (mult_pkg).
REQ-028 The watchdog counter width SHALL be derived from MAX_CYCLES.
REQ-029 A single sub-module, mult_watchdog (counter plus terminal flag), is permitted. The multiplier itself is external.

Verification
REQ-030 MULTU 6 x 3, multiplier model latency 34 -> single-cycle mult_start, then hi=0x00000000, lo=0x00000012.
REQ-031 MULT 6 x 0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEE. MULTU 0xFFFFFFFA x 0xFFFFFFFD -> hi=0xFFFFFFF7, lo=0x00000012.
REQ-032 MFHI presented one cycle after MULT -> stall=1 until IDLE, then rd_valid=1 with the new hi in that cycle.
REQ-033 kill during BUSY after MTLO 0x1234 -> lo stays 0x1234, hi unchanged, and a following MFLO returns 0x1234.
REQ-034 Model holds mult_active=1 indefinitely -> timeout_err=1 after 40 cycles, busy=0, and a subsequent MULTU 6 x 3 completes correctly.
REQ-035 reset asserted in BUSY -> next cycle hi=lo=0, busy=0, mult_start=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared encodings for the HI/LO multiply controller: op codes, FSM states,
// and small helpers used by the controller and its watchdog.
package mult_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MFHI  = 3'd3,
        OP_MFLO  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_ACT = 2'd2,
        ST_BUSY     = 2'd3
    } state_e;

    // Codes 0 and 7 behave as NOP and never stall or get accepted.
    function automatic logic is_hilo_op(input logic [2:0] code);
        return (code != 3'd0) && (code != 3'd7);
    endfunction

    function automatic int unsigned wd_width(input int unsigned max_cycles);
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/mult_watchdog.sv
// Cycle counter guarding the external multiplier; expired_o fires on the
// MAX_CYCLES-th counted cycle after the last clear.
module mult_watchdog
    import mult_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int unsigned CW = wd_width(MAX_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/mult_hilo_ctrl.sv
// HI/LO register file and sequencer for an external multi-cycle multiplier:
// launches MULT/MULTU, stalls dependent HI/LO ops, handles kill and timeout.
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_rs,
    input  logic [31:0] op_rt,
    input  logic        flush,
    input  logic        kill,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        timeout_err,
    output logic        mult_start,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_is_signed,
    input  logic [63:0] mult_s,
    input  logic        mult_active
);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic        abort_q, abort_d;
    logic        timeout_q, timeout_d;

    logic        is_op;
    logic        accept;
    logic        wd_clear;
    logic        wd_count;
    logic        wd_expired;

    assign is_op    = is_hilo_op(op_code);
    assign stall    = op_valid && is_op && (state_q != ST_IDLE);
    assign accept   = op_valid && is_op && !stall && !flush;
    assign wd_clear = (state_q == ST_LAUNCH);
    assign wd_count = (state_q == ST_WAIT_ACT) || (state_q == ST_BUSY);

    mult_watchdog #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .count_i   (wd_count),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        abort_d   = abort_q;
        timeout_d = timeout_q;
        rd_valid  = 1'b0;
        rd_data   = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: begin
                            a_d     = op_rs;
                            b_d     = op_rt;
                            sgn_d   = (op_code == OP_MULT);
                            state_d = ST_LAUNCH;
                        end
                        OP_MFHI: begin
                            rd_valid = 1'b1;
                            rd_data  = hi_q;
                        end
                        OP_MFLO: begin
                            rd_valid = 1'b1;
                            rd_data  = lo_q;
                        end
                        OP_MTHI: hi_d = op_rs;
                        OP_MTLO: lo_d = op_rs;
                        default: ;
                    endcase
                end
            end
            ST_LAUNCH: state_d = ST_WAIT_ACT;
            ST_WAIT_ACT: begin
                if (mult_active) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!mult_active) begin
                    // A kill landing on the completion cycle still discards.
                    if (!abort_q && !kill) begin
                        {hi_d, lo_d} = mult_s;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (kill && (state_q != ST_IDLE)) begin
            abort_d = 1'b1;
        end

        if (wd_expired) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
            hi_d      = hi_q;
            lo_d      = lo_q;
        end

        if (state_d == ST_IDLE) begin
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            sgn_q     <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    assign hi             = hi_q;
    assign lo             = lo_q;
    assign busy           = (state_q != ST_IDLE);
    assign timeout_err    = timeout_q;
    assign mult_start     = (state_q == ST_LAUNCH);
    assign mult_a         = a_q;
    assign mult_b         = b_q;
    assign mult_is_signed = sgn_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: behavioural multiplier with programmable latency,
// reference HI/LO kept as plain variables and updated per architectural op.
`timescale 1ns/1ps
module tb_mult_hilo_ctrl;
    import mult_pkg::*;

    localparam int unsigned MAX_CYCLES = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] op_rs = 32'h0;
    logic [31:0] op_rt = 32'h0;
    logic        flush = 1'b0;
    logic        kill = 1'b0;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        timeout_err;
    logic        mult_start;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_is_signed;
    logic [63:0] mult_s = 64'h0;
    logic        mult_active = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] ref_hi = 32'h0;
    logic [31:0] ref_lo = 32'h0;

    int unsigned m_lat = 34;
    logic        m_hang = 1'b0;
    int unsigned m_cnt = 0;
    logic [63:0] m_prod = 64'h0;

    always #5 clk = ~clk;

    mult_hilo_ctrl #(
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_code        (op_code),
        .op_rs          (op_rs),
        .op_rt          (op_rt),
        .flush          (flush),
        .kill           (kill),
        .stall          (stall),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .hi             (hi),
        .lo             (lo),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .mult_start     (mult_start),
        .mult_a         (mult_a),
        .mult_b         (mult_b),
        .mult_is_signed (mult_is_signed),
        .mult_s         (mult_s),
        .mult_active    (mult_active)
    );

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    // Multiplier: product appears on mult_s only when mult_active falls.
    always @(posedge clk) begin
        if (reset) begin
            mult_active <= 1'b0;
            m_cnt       <= 0;
            mult_s      <= 64'h0;
        end else if (mult_start) begin
            m_prod      <= mul_ref(mult_a, mult_b, mult_is_signed);
            m_cnt       <= m_lat;
            mult_active <= 1'b1;
            mult_s      <= {$urandom, $urandom};
        end else if (mult_active && !m_hang) begin
            if (m_cnt <= 1) begin
                mult_active <= 1'b0;
                mult_s      <= m_prod;
            end else begin
                m_cnt  <= m_cnt - 1;
                mult_s <= {$urandom, $urandom};
            end
        end
    end

    task automatic idle_inputs();
        op_valid = 1'b0;
        op_code  = 3'd0;
        op_rs    = 32'h0;
        op_rt    = 32'h0;
        flush    = 1'b0;
        kill     = 1'b0;
    endtask

    // Present one op for one cycle from IDLE; for multiplies, wait for the
    // return to IDLE. discard=1 means the product must not reach HI/LO.
    task automatic apply_op(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt,
                            input bit fl, input bit discard, input string name, output int cyc);
        bit          acc;
        bit          is_mul;
        bit          exp_rv;
        bit          stable;
        bit          timed_out;
        int          starts;
        logic [31:0] exp_rd;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        s0;
        acc    = !fl && (code >= 3'd1) && (code <= 3'd6);
        is_mul = acc && ((code == 3'd1) || (code == 3'd2));
        exp_rv = acc && ((code == 3'd3) || (code == 3'd4));
        exp_rd = !exp_rv ? 32'h0 : (code == 3'd3) ? ref_hi : ref_lo;
        cyc    = 0;

        @(negedge clk);
        op_valid = 1'b1; op_code = code; op_rs = rs; op_rt = rt; flush = fl;
        #1;
        n_checks++;
        if (rd_valid !== exp_rv) begin
            n_fail++; $display("FAIL %s rd_valid: got %b expected %b", name, rd_valid, exp_rv);
        end
        n_checks++;
        if (rd_data !== exp_rd) begin
            n_fail++; $display("FAIL %s rd_data: got %h expected %h", name, rd_data, exp_rd);
        end
        @(negedge clk);
        op_valid = 1'b0; op_code = 3'd0; flush = 1'b0;
        #1;

        if (is_mul) begin
            a0 = mult_a; b0 = mult_b; s0 = mult_is_signed;
            n_checks++;
            if ({a0, b0, s0} !== {rs, rt, (code == 3'd1)}) begin
                n_fail++;
                $display("FAIL %s operands: got a=%h b=%h s=%b expected a=%h b=%h s=%b",
                         name, a0, b0, s0, rs, rt, (code == 3'd1));
            end
            starts = 0; stable = 1'b1; timed_out = 1'b0;
            while (busy === 1'b1) begin
                if (cyc >= 200) begin
                    timed_out = 1'b1;
                    break;
                end
                if (mult_start === 1'b1) starts++;
                if ((mult_a !== a0) || (mult_b !== b0) || (mult_is_signed !== s0) || (stall !== 1'b0))
                    stable = 1'b0;
                cyc++;
                @(negedge clk);
                #1;
            end
            n_checks++;
            if (timed_out) begin
                n_fail++; $display("FAIL %s completion: still busy after %0d cycles, expected idle", name, cyc);
            end
            n_checks++;
            if (starts != 1) begin
                n_fail++; $display("FAIL %s mult_start pulses: got %0d expected 1", name, starts);
            end
            n_checks++;
            if (!stable) begin
                n_fail++; $display("FAIL %s operand hold/stall: got unstable expected stable", name);
            end
            if (!discard) {ref_hi, ref_lo} = mul_ref(rs, rt, (code == 3'd1));
        end else begin
            if (acc && (code == 3'd5)) ref_hi = rs;
            if (acc && (code == 3'd6)) ref_lo = rs;
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL %s busy: got %b expected 0", name, busy);
            end
        end
        n_checks++;
        if (hi !== ref_hi) begin
            n_fail++; $display("FAIL %s hi: got %h expected %h", name, hi, ref_hi);
        end
        n_checks++;
        if (lo !== ref_lo) begin
            n_fail++; $display("FAIL %s lo: got %h expected %h", name, lo, ref_lo);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({hi, lo} !== 64'h0) begin
            n_fail++; $display("FAIL reset hilo: got %h_%h expected 0", hi, lo);
        end
        n_checks++;
        if ({busy, stall, rd_valid, mult_start, mult_is_signed, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset flags: got busy=%b stall=%b rd_valid=%b start=%b sgn=%b to=%b expected all 0",
                     busy, stall, rd_valid, mult_start, mult_is_signed, timeout_err);
        end
        n_checks++;
        if ({rd_data, mult_a, mult_b} !== 96'h0) begin
            n_fail++; $display("FAIL reset data: got rd=%h a=%h b=%h expected 0", rd_data, mult_a, mult_b);
        end
        reset = 1'b0;
        ref_hi = 32'h0;
        ref_lo = 32'h0;
    endtask

    task automatic test_directed_products();
        int cyc;
        m_lat = 34;
        apply_op(3'd2, 32'd6, 32'd3, 1'b0, 1'b0, "multu_6x3", cyc);
        n_checks++;
        if ({hi, lo} !== 64'h00000000_00000012) begin
            n_fail++; $display("FAIL multu_6x3 const: got %h_%h expected 00000000_00000012", hi, lo);
        end
        apply_op(3'd1, 32'd6, 32'hFFFFFFFD, 1'b0, 1'b0, "mult_signed", cyc);
        n_checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEE) begin
            n_fail++; $display("FAIL mult_signed const: got %h_%h expected FFFFFFFF_FFFFFFEE", hi, lo);
        end
        apply_op(3'd2, 32'hFFFFFFFA, 32'hFFFFFFFD, 1'b0, 1'b0, "multu_big", cyc);
        n_checks++;
        if ({hi, lo} !== 64'hFFFFFFF7_00000012) begin
            n_fail++; $display("FAIL multu_big const: got %h_%h expected FFFFFFF7_00000012", hi, lo);
        end
    endtask

    task automatic test_moves_and_flush();
        int cyc;
        apply_op(3'd5, 32'hA5A5_0001, 32'h0, 1'b0, 1'b0, "mthi", cyc);
        apply_op(3'd6, 32'h5A5A_0002, 32'h0, 1'b0, 1'b0, "mtlo", cyc);
        apply_op(3'd3, 32'h0, 32'h0, 1'b0, 1'b0, "mfhi", cyc);
        apply_op(3'd4, 32'h0, 32'h0, 1'b0, 1'b0, "mflo", cyc);
        apply_op(3'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, "nop", cyc);
        apply_op(3'd7, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, "op7", cyc);
        apply_op(3'd5, 32'h1111_2222, 32'h0, 1'b1, 1'b0, "flush_mthi", cyc);
        apply_op(3'd3, 32'h0, 32'h0, 1'b1, 1'b0, "flush_mfhi", cyc);
        apply_op(3'd2, 32'd9, 32'd9, 1'b1, 1'b0, "flush_multu", cyc);
    endtask

    task automatic test_mfhi_stall();
        int          n;
        bit          bad;
        logic [31:0] rs;
        logic [31:0] rt;
        rs = $urandom | 32'h8000_0000;
        rt = $urandom_range(3, 1000);
        m_lat = $urandom_range(5, 20);
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd1; op_rs = rs; op_rt = rt;
        @(negedge clk);
        op_code = 3'd3; op_rs = 32'h0; op_rt = 32'h0;
        {ref_hi, ref_lo} = mul_ref(rs, rt, 1'b1);
        #1;
        n = 0; bad = 1'b0;
        while ((busy === 1'b1) && (n < 200)) begin
            if ((stall !== 1'b1) || (rd_valid !== 1'b0)) bad = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (bad || (n == 0) || (n >= 200)) begin
            n_fail++; $display("FAIL mfhi_stall hold: got bad=%b cycles=%0d expected stall over 1..199 cycles", bad, n);
        end
        n_checks++;
        if ({stall, rd_valid} !== 2'b01) begin
            n_fail++; $display("FAIL mfhi_stall release: got stall=%b rd_valid=%b expected 0 1", stall, rd_valid);
        end
        n_checks++;
        if (rd_data !== ref_hi) begin
            n_fail++; $display("FAIL mfhi_stall data: got %h expected %h", rd_data, ref_hi);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_kill();
        int cyc;
        m_lat = 34;
        apply_op(3'd6, 32'h0000_1234, 32'h0, 1'b0, 1'b0, "kill_mtlo", cyc);
        apply_op(3'd5, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, "kill_mthi", cyc);
        fork
            apply_op(3'd2, $urandom, $urandom, 1'b0, 1'b1, "kill_busy", cyc);
            begin
                int n_act;
                n_act = 0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if ((busy === 1'b1) && (mult_active === 1'b1)) n_act++;
                    if (n_act == 5) break;
                end
                kill = 1'b1;
                @(negedge clk);
                kill = 1'b0;
            end
        join
        n_checks++;
        if ({hi, lo} !== 64'hCAFEF00D_00001234) begin
            n_fail++; $display("FAIL kill_busy const: got %h_%h expected CAFEF00D_00001234", hi, lo);
        end
        apply_op(3'd4, 32'h0, 32'h0, 1'b0, 1'b0, "kill_mflo", cyc);

        m_lat = 10;
        fork
            apply_op(3'd1, $urandom, $urandom, 1'b0, 1'b1, "kill_complete", cyc);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (mult_active === 1'b1) seen = 1'b1;
                    else if (seen && (busy === 1'b1)) break;
                end
                kill = 1'b1;
                @(negedge clk);
                kill = 1'b0;
            end
        join

        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        apply_op(3'd2, 32'd6, 32'd3, 1'b0, 1'b0, "kill_idle", cyc);
    endtask

    task automatic test_random();
        int          cyc;
        logic [2:0]  code;
        logic [31:0] rs;
        logic [31:0] rt;
        bit          fl;
        for (int i = 0; i < 24; i++) begin
            code  = 3'($urandom_range(0, 7));
            rs    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom;
            rt    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            fl    = ($urandom_range(0, 4) == 0);
            m_lat = $urandom_range(1, 25);
            apply_op(code, rs, rt, fl, 1'b0, "random", cyc);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        m_lat  = 34;
        m_hang = 1'b1;
        apply_op(3'd2, $urandom, $urandom, 1'b0, 1'b1, "timeout", cyc);
        n_checks++;
        if ({timeout_err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL timeout flags: got to=%b busy=%b expected 1 0", timeout_err, busy);
        end
        n_checks++;
        if (cyc != MAX_CYCLES + 1) begin
            n_fail++; $display("FAIL timeout cycles: got %0d busy cycles expected %0d", cyc, MAX_CYCLES + 1);
        end
        m_hang = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mult_active === 1'b0) break;
            @(negedge clk);
        end
        apply_op(3'd2, 32'd6, 32'd3, 1'b0, 1'b0, "after_timeout", cyc);
        n_checks++;
        if ({timeout_err, lo} !== {1'b1, 32'h12}) begin
            n_fail++; $display("FAIL after_timeout: got to=%b lo=%h expected 1 00000012", timeout_err, lo);
        end
    endtask

    task automatic test_reset_busy();
        int n_act;
        m_lat = 34;
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd2; op_rs = 32'd7; op_rt = 32'd7;
        @(negedge clk);
        idle_inputs();
        n_act = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((busy === 1'b1) && (mult_active === 1'b1)) n_act++;
            if (n_act == 4) break;
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({hi, lo} !== 64'h0) begin
            n_fail++; $display("FAIL reset_busy hilo: got %h_%h expected 0", hi, lo);
        end
        n_checks++;
        if ({busy, mult_start, timeout_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_busy flags: got busy=%b start=%b to=%b expected 0 0 0",
                               busy, mult_start, timeout_err);
        end
        reset = 1'b0;
        ref_hi = 32'h0;
        ref_lo = 32'h0;
        repeat (60) @(negedge clk);
        n_checks++;
        if ({hi, lo, busy} !== 65'h0) begin
            n_fail++; $display("FAIL reset_busy late: got %h_%h busy=%b expected 0", hi, lo, busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish by 500us, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed_products();
        test_moves_and_flush();
        test_mfhi_stall();
        test_kill();
        test_random();
        test_timeout();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
